pb_event_ctrl: RTL and testbench

Multi-button debounce controller and event scheduler for the multi-cycle CPU board front-end. It samples N raw push-buttons against one shared tick prescaler, so a single timebase serves all buttons instead of one counter per `pbdebounce` instance. It holds per-button stability counters and arbitrates simultaneous press/release edges into a small event FIFO. The FIFO feeds the step/mode logic through a valid/ready handshake.

---
 rtl/pb_pkg.sv | 29 ++
 rtl/pb_evt_fifo.sv | 72 +++++++
 rtl/pb_event_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pb_event_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_pkg.sv
// Shared types, defaults and helpers for the push-button event controller.
package pb_pkg;

    localparam int TICK_DIV_DEF     = 50000;
    localparam int STABLE_TICKS_DEF = 8;

    // Widest button index for up to 8 buttons; narrower designs zero-extend.
    localparam int ID_W_MAX = 3;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic                press;
    } evt_t;

    // Ceiling log2 with a floor of 1 so that every derived vector has a bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/pb_evt_fifo.sv
// Small synchronous FIFO holding button events; head entry is always visible.
module pb_evt_fifo
    import pb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointer advance with explicit wrap so any depth works, not only 2^PTR_W.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign head_data = mem_r[rd_ptr_r];

    // A push is refused in the full cycle even if a pop frees a slot at the same edge.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pb_event_ctrl.sv
// Multi-button debouncer sharing one sample-tick prescaler, with an
// arbitrated event FIFO toward the step/mode logic.
module pb_event_ctrl
    import pb_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = TICK_DIV_DEF,
    parameter int STABLE_TICKS = STABLE_TICKS_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_BTN-1:0]        button,
    output logic [N_BTN-1:0]        btn_level,
    output logic [N_BTN-1:0]        press_pulse,
    output logic [N_BTN-1:0]        release_pulse,
    output logic                    evt_valid,
    output logic [clog2(N_BTN)-1:0] evt_id,
    output logic                    evt_press,
    input  logic                    evt_ready,
    output logic                    overflow
);

    localparam int ID_W   = clog2(N_BTN);
    localparam int PCNT_W = clog2(TICK_DIV);
    localparam int SCNT_W = clog2(STABLE_TICKS);

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(STABLE_TICKS - 1);

    logic [N_BTN-1:0]  sync1_r;
    logic [N_BTN-1:0]  sync2_r;
    logic [PCNT_W-1:0] pcnt_r;
    logic [SCNT_W-1:0] scnt_r [N_BTN];
    logic [N_BTN-1:0]  btn_level_r;
    logic [N_BTN-1:0]  press_r;
    logic [N_BTN-1:0]  release_r;
    logic [N_BTN-1:0]  pend_r;
    logic [N_BTN-1:0]  pdir_r;
    logic              overflow_r;

    logic              tick_s;
    logic [N_BTN-1:0]  flip_s;
    logic [N_BTN-1:0]  grant_s;
    logic [ID_W-1:0]   grant_id_s;
    logic              push_s;
    evt_t              push_evt_s;
    evt_t              head_evt_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;

    assign tick_s = (pcnt_r == PCNT_LAST);

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= {N_BTN{1'b0}};
            sync2_r <= {N_BTN{1'b0}};
        end else begin
            sync1_r <= button;
            sync2_r <= sync1_r;
        end
    end

    // Shared prescaler producing one sample tick every TICK_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_r <= {PCNT_W{1'b0}};
        end else if (tick_s) begin
            pcnt_r <= {PCNT_W{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PCNT_W'(1);
        end
    end

    // A button flips on the tick that completes its run of mismatching samples.
    always_comb begin
        flip_s = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            if (tick_s && (sync2_r[i] != btn_level_r[i]) && (scnt_r[i] == SCNT_LAST)) begin
                flip_s[i] = 1'b1;
            end else begin
                flip_s[i] = 1'b0;
            end
        end
    end

    // Per-button stability counters, advanced only on sample ticks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                scnt_r[i] <= {SCNT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!tick_s) begin
                    scnt_r[i] <= scnt_r[i];
                end else if (sync2_r[i] == btn_level_r[i]) begin
                    scnt_r[i] <= {SCNT_W{1'b0}};
                end else if (scnt_r[i] == SCNT_LAST) begin
                    scnt_r[i] <= {SCNT_W{1'b0}};
                end else begin
                    scnt_r[i] <= scnt_r[i] + SCNT_W'(1);
                end
            end
        end
    end

    // Debounced levels and their edge pulses, updated in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level_r <= {N_BTN{1'b0}};
            press_r     <= {N_BTN{1'b0}};
            release_r   <= {N_BTN{1'b0}};
        end else begin
            btn_level_r <= btn_level_r ^ flip_s;
            press_r     <= flip_s & ~btn_level_r;
            release_r   <= flip_s & btn_level_r;
        end
    end

    // Fixed-priority arbiter: lowest pending index wins whenever the FIFO has room.
    always_comb begin
        grant_id_s = {ID_W{1'b0}};
        grant_s    = {N_BTN{1'b0}};
        push_s     = 1'b0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            grant_id_s = pend_r[i] ? ID_W'(i) : grant_id_s;
        end
        if ((|pend_r) && !fifo_full_s) begin
            push_s              = 1'b1;
            grant_s[grant_id_s] = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        push_evt_s.id    = ID_W_MAX'(grant_id_s);
        push_evt_s.press = pdir_r[grant_id_s];
    end

    // Pending flags; a flip on an ungranted pending button keeps only the newest direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r     <= {N_BTN{1'b0}};
            pdir_r     <= {N_BTN{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            pend_r <= (pend_r & ~grant_s) | flip_s;
            pdir_r <= (pdir_r & ~flip_s) | (flip_s & ~btn_level_r);
            if (|(flip_s & pend_r & ~grant_s)) begin
                overflow_r <= 1'b1;
            end
        end
    end

    pb_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(evt_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_evt_s),
        .pop       (evt_ready),
        .head_data (head_evt_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign btn_level     = btn_level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign overflow      = overflow_r;
    assign evt_valid     = !fifo_empty_s;
    assign evt_id        = head_evt_s.id[ID_W-1:0];
    assign evt_press     = head_evt_s.press;

endmodule

// File: tb/tb_pb_event_ctrl.sv
// Directed bench for pb_event_ctrl with an event scoreboard queue.
module tb_pb_event_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic [3:0] btn_level;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_press;
    logic       evt_ready;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int press_cnt [4];
    int rel_cnt [4];

    pb_event_ctrl #(
        .N_BTN        (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button        (button),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .evt_valid     (evt_valid),
        .evt_id        (evt_id),
        .evt_press     (evt_press),
        .evt_ready     (evt_ready),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    // Count every cycle a pulse is high, per button.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (press_pulse[i] === 1'b1) press_cnt[i] <= press_cnt[i] + 1;
            if (release_pulse[i] === 1'b1) rel_cnt[i] <= rel_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_evt(input int id, input int press);
        exp_q.push_back(id * 2 + press);
    endtask

    task automatic wait_level(input string tag, input logic [3:0] mask,
                              input logic [3:0] val, input int bound);
        int n = 0;
        while (((btn_level & mask) !== val) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, int'(btn_level & mask), int'(val));
    endtask

    task automatic pop_expect(input string tag, input int bound);
        int n = 0;
        int exp_v;
        evt_ready = 1'b1;
        while ((evt_valid !== 1'b1) && (n < bound)) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, int'(evt_valid), 1);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk(tag, int'({evt_id, evt_press}), exp_v);
        @(negedge clk);
    endtask

    initial begin
        int p0;
        int r0;
        rst       = 1'b1;
        button    = 4'b0000;
        evt_ready = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        chk("rst_level", int'(btn_level), 0);
        chk("rst_pulses", int'({press_pulse, release_pulse}), 0);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_ovf", int'(overflow), 0);

        // Clean press of button 2
        button = 4'b0100;
        expect_evt(2, 1);
        wait_level("press2_level", 4'b0100, 4'b0100, 16);
        pop_expect("press2_evt", 4);
        chk("press2_drain", int'(evt_valid), 0);
        evt_ready = 1'b0;
        chk("press2_pcnt", press_cnt[2], 1);

        // Bounce on button 0 never survives three ticks
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        for (int k = 0; k < 8; k++) begin
            button[0] = ~button[0];
            idle(5);
        end
        idle(20);
        chk("bounce_level", int'(btn_level[0]), 0);
        chk("bounce_press", press_cnt[0] - p0, 0);
        chk("bounce_rel", rel_cnt[0] - r0, 0);
        chk("bounce_empty", int'(evt_valid), 0);

        // Simultaneous presses on 3, 1, 0 drain in index order
        button = 4'b1111;
        expect_evt(0, 1);
        expect_evt(1, 1);
        expect_evt(3, 1);
        wait_level("simul_level", 4'b1111, 4'b1111, 16);
        idle(4);
        pop_expect("simul_e0", 0);
        pop_expect("simul_e1", 0);
        pop_expect("simul_e2", 0);
        chk("simul_drain", int'(evt_valid), 0);
        evt_ready = 1'b0;

        // Fill the FIFO with four releases, then a fifth flip waits in pend
        button = 4'b0000;
        expect_evt(0, 0);
        expect_evt(1, 0);
        expect_evt(2, 0);
        expect_evt(3, 0);
        wait_level("full_rel", 4'b1111, 4'b0000, 16);
        idle(6);
        button = 4'b0001;
        expect_evt(0, 1);
        wait_level("full_p0", 4'b0001, 4'b0001, 16);
        idle(3);
        chk("full_ovf_pre", int'(overflow), 0);
        for (int k = 0; k < 5; k++) begin
            pop_expect($sformatf("full_e%0d", k), 3);
        end
        chk("full_drain", int'(evt_valid), 0);
        chk("full_ovf_post", int'(overflow), 0);
        evt_ready = 1'b0;

        // Collision: button 1 presses and releases while the FIFO is full
        button = 4'b1100;
        expect_evt(0, 0);
        expect_evt(2, 1);
        expect_evt(3, 1);
        wait_level("coll_fill", 4'b1111, 4'b1100, 16);
        idle(4);
        button = 4'b1101;
        expect_evt(0, 1);
        wait_level("coll_p0", 4'b0001, 4'b0001, 16);
        idle(3);
        button = 4'b1111;
        wait_level("coll_p1", 4'b0010, 4'b0010, 16);
        idle(2);
        chk("coll_ovf_pre", int'(overflow), 0);
        button = 4'b1101;
        expect_evt(1, 0);
        wait_level("coll_r1", 4'b0010, 4'b0000, 16);
        idle(2);
        chk("coll_ovf", int'(overflow), 1);
        for (int k = 0; k < 5; k++) begin
            pop_expect($sformatf("coll_e%0d", k), 3);
        end
        chk("coll_drain", int'(evt_valid), 0);
        evt_ready = 1'b0;

        // Release everything, then reset in the middle of debouncing button 2
        button = 4'b0000;
        expect_evt(0, 0);
        expect_evt(2, 0);
        expect_evt(3, 0);
        wait_level("pre_rst_rel", 4'b1111, 4'b0000, 16);
        idle(4);
        for (int k = 0; k < 3; k++) begin
            pop_expect($sformatf("pre_rst_e%0d", k), 3);
        end
        evt_ready = 1'b0;
        button = 4'b0100;
        begin
            int n = 0;
            while ((dut.scnt_r[2] !== 2'd2) && (n < 16)) begin
                @(negedge clk);
                n++;
            end
            chk("mid_scnt", int'(dut.scnt_r[2]), 2);
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_level", int'(btn_level), 0);
        chk("mid_rst_valid", int'(evt_valid), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_pulses", int'({press_pulse, release_pulse}), 0);
        idle(2);
        rst = 1'b0;
        exp_q.delete();
        expect_evt(2, 1);
        idle(6);
        chk("post_rst_level", int'(btn_level), 0);
        chk("post_rst_valid", int'(evt_valid), 0);
        pop_expect("post_rst_e", 16);
        chk("post_rst_held", int'(btn_level), 4);
        evt_ready = 1'b0;
        idle(2);

        // Total pulse counts over the whole run
        chk("tot_press0", press_cnt[0], 3);
        chk("tot_rel0", rel_cnt[0], 3);
        chk("tot_press1", press_cnt[1], 2);
        chk("tot_rel1", rel_cnt[1], 2);
        chk("tot_press2", press_cnt[2], 3);
        chk("tot_rel2", rel_cnt[2], 2);
        chk("tot_press3", press_cnt[3], 2);
        chk("tot_rel3", rel_cnt[3], 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
